// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//
// Instruction-fetch sequencer in front of a combinational instruction ROM.
// Owns the fetch PC, drives the ROM word address, captures ROM data into a
// two-entry prefetch buffer and presents {pc, inst} at the buffer head to
// decode. Taken branches redirect fetch and flush wrong-path entries. Fetch
// stops after the last ROM word and reports halted once the buffer drains.
//
// Optional build macro:
//   FETCH_STATS_EN  adds stat_fetch_o, a saturating count of completed
//                   decode handshakes (cleared only by reset).
//
// Ports:
//   clk_i          in   1       clock, all state on rising edge
//   reset_i        in   1       synchronous active-high reset
//   start_i        in   1       pulse: leave IDLE, begin fetching at word 0
//   rom_addr_o     out  ADDR_W  ROM word address (registered fetch PC)
//   rom_data_i     in   INST_W  ROM word for rom_addr_o, same cycle
//   inst_o         out  INST_W  instruction at buffer head
//   pc_o           out  ADDR_W  word address of inst_o
//   inst_valid_o   out  1       buffer head valid
//   inst_ready_i   in   1       decode accepts the head
//   redirect_i     in   1       taken branch/jump: flush and refetch
//   redirect_pc_i  in   ADDR_W  redirect target (word address)
//   state_o        out  2       debug view of the sequencer state
//                               (0 IDLE, 1 RUN, 2 DRAIN, 3 HALT)
//   halted_o       out  1       fetch finished and buffer empty
//   stat_fetch_o   out  16      completed handshakes (FETCH_STATS_EN only)
//
// Handshake: the head entry transfers to decode on a rising edge where
// inst_valid_o and inst_ready_i are both 1. inst_valid_o never depends on
// inst_ready_i, and while inst_valid_o=1 and no handshake occurs, inst_o and
// pc_o hold their values (redirect and reset excepted, which flush).
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int ROM_DEPTH = 64,
    parameter int INST_W    = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_data_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [1:0]        state_o,
    output logic              halted_o
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]       stat_fetch_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(ROM_DEPTH - 1);

    // Sequencer state and fetch pointer
    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] fetch_pc_d;

    // Prefetch buffer: entry 0 is always the head, entry 1 the tail.
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic [ADDR_W-1:0] e0_pc_q;
    logic [INST_W-1:0] e0_inst_q;
    logic [ADDR_W-1:0] e1_pc_q;
    logic [INST_W-1:0] e1_inst_q;

    // Per-cycle control
    logic       pop;
    logic       push;
    logic       flush;
    logic [1:0] count_after_pop;

    // Moore outputs straight from registers
    assign rom_addr_o   = fetch_pc_q;
    assign inst_o       = e0_inst_q;
    assign pc_o         = e0_pc_q;
    assign inst_valid_o = (count_q != 2'd0);
    assign halted_o     = (state_q == ST_HALT);
    assign state_o      = state_q;

    assign pop             = inst_valid_o & inst_ready_i;
    assign count_after_pop = count_q - {1'b0, pop};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        flush      = 1'b0;

        if (state_q == ST_IDLE) begin
            // Only start_i matters here; a coincident redirect is dropped.
            if (start_i) begin
                state_d = ST_RUN;
            end
        end else if (redirect_i) begin
            // A same-cycle pop still completes; everything left is flushed.
            flush = 1'b1;
            if (redirect_pc_i <= LAST_PC) begin
                fetch_pc_d = redirect_pc_i;
                state_d    = ST_RUN;
            end else begin
                // Out-of-range target: halt without loading it, so the ROM
                // address never leaves the legal program space.
                state_d = ST_HALT;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    // Room exists when the post-pop occupancy is below two.
                    if (count_after_pop != 2'd2) begin
                        push = 1'b1;
                        if (fetch_pc_q == LAST_PC) begin
                            // Last word fetched: hold the pointer, no wrap.
                            state_d = ST_DRAIN;
                        end else begin
                            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Move on as the final entry leaves, so halted_o rises
                    // on the cycle right after the last handshake.
                    if (count_after_pop == 2'd0) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (flush) begin
            count_d = 2'd0;
        end else begin
            count_d = count_after_pop + {1'b0, push};
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= '0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Prefetch buffer storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            e0_pc_q   <= '0;
            e0_inst_q <= '0;
            e1_pc_q   <= '0;
            e1_inst_q <= '0;
        end else if (!flush) begin
            if (pop) begin
                e0_pc_q   <= e1_pc_q;
                e0_inst_q <= e1_inst_q;
            end
            // A push lands in the first free slot after the pop; when that is
            // slot 0 it overrides the shift above.
            if (push) begin
                if (count_after_pop == 2'd0) begin
                    e0_pc_q   <= fetch_pc_q;
                    e0_inst_q <= rom_data_i;
                end else begin
                    e1_pc_q   <= fetch_pc_q;
                    e1_inst_q <= rom_data_i;
                end
            end
        end
    end

`ifdef FETCH_STATS_EN
    // -------------------------------------------------------------------------
    // Handshake counter: saturating, survives redirects
    // -------------------------------------------------------------------------
    logic [15:0] stat_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_q <= '0;
        end else if (pop && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_fetch_o = stat_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//
// Drives inst_fetch_ctrl (ROM_DEPTH=21) with directed scenarios followed by a
// randomized phase. A behavioural model (state name, fetch pointer and a
// queue standing in for the prefetch buffer) predicts every decode
// handshake; predicted {pc, inst} pairs go into exp_q and a separate monitor
// pops and compares them whenever the DUT completes a handshake.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

    localparam int ADDR_W    = 32;
    localparam int ROM_DEPTH = 21;
    localparam int INST_W    = 32;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_HALT  = 3;

    // ---------------------------------------------------------------- clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT io
    logic              reset_i;
    logic              start_i;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [INST_W-1:0] rom_data_i;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] pc_o;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic [1:0]        state_o;
    logic              halted_o;
`ifdef FETCH_STATS_EN
    logic [15:0]       stat_fetch_o;
`endif

    inst_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .ROM_DEPTH(ROM_DEPTH),
        .INST_W   (INST_W)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .rom_addr_o   (rom_addr_o),
        .rom_data_i   (rom_data_i),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .state_o      (state_o),
        .halted_o     (halted_o)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetch_o (stat_fetch_o)
`endif
    );

    // ---------------------------------------------------------------- ROM
    logic [INST_W-1:0] rom_mem [0:31];
    assign rom_data_i = (rom_addr_o < ROM_DEPTH) ? rom_mem[rom_addr_o[4:0]] : '0;

    // ---------------------------------------------------------------- scoreboard
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];

    // ---------------------------------------------------------------- model
    int m_mode     = M_IDLE;
    int m_fetch_pc = 0;
    int m_buf[$];
    int m_stat     = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT's visible state against the model's current prediction.
    task automatic check_outputs();
        check("inst_valid", 64'(inst_valid_o), 64'(m_buf.size() > 0));
        check("halted", 64'(halted_o), 64'(m_mode == M_HALT));
        check("rom_addr_bound", 64'(rom_addr_o <= ROM_DEPTH - 1), 64'(1));
        if (m_mode != M_HALT) begin
            check("rom_addr", 64'(rom_addr_o), 64'(m_fetch_pc));
        end
        if (m_buf.size() > 0) begin
            check("pc_o", 64'(pc_o), 64'(m_buf[0]));
            check("inst_o", 64'(inst_o), 64'(rom_mem[m_buf[0]]));
        end
`ifdef FETCH_STATS_EN
        check("stat_fetch", 64'(stat_fetch_o), 64'(m_stat));
`endif
    endtask

    // Advance the model by one clock given the inputs applied this cycle.
    task automatic model_step(input bit rst, input bit start, input bit ready,
                              input bit redir, input int rpc);
        bit pop;
        pop = (m_buf.size() > 0) && ready;
        if (rst) begin
            m_mode     = M_IDLE;
            m_fetch_pc = 0;
            m_buf.delete();
            m_stat     = 0;
            return;
        end
        if (m_mode == M_IDLE) begin
            if (start) m_mode = M_RUN;
            return;
        end
        if (pop) begin
            exp_q.push_back({32'(m_buf[0]), rom_mem[m_buf[0]]});
            void'(m_buf.pop_front());
            if (m_stat < 65535) m_stat++;
        end
        if (redir) begin
            m_buf.delete();
            if (rpc < ROM_DEPTH) begin
                m_fetch_pc = rpc;
                m_mode     = M_RUN;
            end else begin
                m_mode = M_HALT;
            end
            return;
        end
        if (m_mode == M_RUN && m_buf.size() < 2) begin
            m_buf.push_back(m_fetch_pc);
            if (m_fetch_pc == ROM_DEPTH - 1) m_mode = M_DRAIN;
            else m_fetch_pc++;
        end else if (m_mode == M_DRAIN && m_buf.size() == 0) begin
            m_mode = M_HALT;
        end
    endtask

    // One clock: check outputs after the edge, then apply the next inputs.
    task automatic cyc(input bit rst, input bit start, input bit ready,
                       input bit redir, input int rpc);
        @(posedge clk);
        #1;
        check_outputs();
        reset_i       = rst;
        start_i       = start;
        inst_ready_i  = ready;
        redirect_i    = redir;
        redirect_pc_i = 32'(rpc);
        model_step(rst, start, ready, redir, rpc);
    endtask

    task automatic check_reset_values();
        check("rst_pc_o", 64'(pc_o), 64'(0));
        check("rst_inst_o", 64'(inst_o), 64'(0));
        check("rst_rom_addr", 64'(rom_addr_o), 64'(0));
        check("rst_state_idle", 64'(state_o), 64'(0));
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (inst_valid_o === 1'b1 && inst_ready_i === 1'b1 && reset_i === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL handshake: got pc %0d with nothing expected at %0t",
                         pc_o, $time);
            end else begin
                check("handshake", {pc_o, inst_o}, exp_q.pop_front());
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        reset_i       = 1'b1;
        start_i       = 1'b0;
        inst_ready_i  = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        rom_mem[0]    = 32'h40220000;
        for (int i = 1; i < 32; i++) rom_mem[i] = $urandom;

        // Reset
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check_reset_values();

        // Streaming from start with decode always ready
        cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0);

        // Backpressure for five cycles, then release
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            if (m_buf.size() > 0 && m_buf[0] == 7) break;
            cyc(0, 0, 1, 0, 0);
        end
        check("reach_head_7", 64'(m_buf.size() > 0 && m_buf[0] == 7), 64'(1));

        // Redirect to 15 while 7,8 are buffered and decode is ready
        cyc(0, 0, 1, 1, 15);

        // Run to the end of the program space
        for (int i = 0; i < 60; i++) begin
            if (m_mode == M_HALT) break;
            cyc(0, 0, 1, 0, 0);
        end
        check("reach_halt", 64'(m_mode == M_HALT), 64'(1));
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        // Out-of-range redirect, then back into range
        cyc(0, 0, 1, 1, 64);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 2);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            bit rst;
            bit start;
            bit ready;
            bit redir;
            rst   = ($urandom_range(0, 99) == 0);
            start = (m_mode == M_IDLE) ? ($urandom_range(0, 3) == 0)
                                       : ($urandom_range(0, 19) == 0);
            ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 14) == 0);
            cyc(rst, start, ready, redir, int'($urandom_range(0, 25)));
        end

        // Reset with a full buffer and a pending handshake
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
        check("buffer_full_before_reset", 64'(m_buf.size()), 64'(2));
        cyc(1, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check_reset_values();

        // Start and redirect together in IDLE: start wins, fetch from 0
        cyc(0, 1, 1, 1, 10);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0);

        // Let the monitor drain the expected queue
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("exp_q_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
